// File: rtl/tron_pkg.sv
// Shared play-field constants, cell codes and FSM encoding
// for the tron collision checker.
package tron_pkg;

   localparam int FIELD_W = 160;
   localparam int FIELD_H = 120;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_A     = 2'b01;
   localparam logic [1:0] CELL_B     = 2'b10;
   localparam logic [1:0] CELL_WALL  = 2'b11;

   localparam logic [1:0] ST_CLEAR = 2'd0;
   localparam logic [1:0] ST_IDLE  = 2'd1;
   localparam logic [1:0] ST_READ  = 2'd2;
   localparam logic [1:0] ST_CHECK = 2'd3;

   localparam logic PLAYER_A = 1'b0;
   localparam logic PLAYER_B = 1'b1;

   function automatic logic [1:0] cell_code(input logic player);
      return (player == PLAYER_B) ? CELL_B : CELL_A;
   endfunction

endpackage

// File: rtl/occupancy_ram.sv
// Single-port 2-bit occupancy map, registered read,
// read-during-write returns the old cell content.
module occupancy_ram #(
   parameter int DEPTH  = 19200,
   parameter int ADDR_W = 15
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [1:0]        wdata_i,
   output logic [1:0]        rdata_o
);

   logic [1:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[addr_i] <= wdata_i;
      end
      rdata_o <= mem[addr_i];
   end

endmodule

// File: rtl/trail_collision_checker.sv
// Per-request read/check/claim of tron head cells against
// a private occupancy map, with a full wipe after reset/clear.
module trail_collision_checker #(
   parameter int FIELD_W = 160,
   parameter int FIELD_H = 120,
   parameter int ADDR_W  = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [7:0] req_x,
   input  logic [6:0] req_y,
   input  logic       req_player,
   output logic       resp_valid,
   output logic       resp_hit,
   output logic       resp_player,
   output logic [1:0] resp_owner,
   output logic       crash_a,
   output logic       crash_b,
   output logic       busy_clear
);

   import tron_pkg::*;

   localparam int DEPTH = FIELD_W * FIELD_H;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
   logic [7:0]        x_q, x_d;
   logic [6:0]        y_q, y_d;
   logic              player_q, player_d;
   logic              oob_q, oob_d;
   logic              crash_a_q, crash_a_d;
   logic              crash_b_q, crash_b_d;

   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [1:0]        ram_wdata;
   logic [1:0]        ram_rdata;
   logic [ADDR_W-1:0] rd_addr;
   logic              hit;
   logic              fire;

   assign rd_addr = ADDR_W'(int'(y_q) * FIELD_W + int'(x_q));
   assign hit     = oob_q || (ram_rdata != CELL_EMPTY);

   // A clear or reset in CHECK kills the response as well as the write.
   assign fire = (state_q == ST_CHECK) && !clear && !reset;

   assign req_ready   = (state_q == ST_IDLE) && !clear;
   assign busy_clear  = (state_q == ST_CLEAR);
   assign resp_valid  = fire;
   assign resp_hit    = fire && hit;
   assign resp_player = fire && player_q;
   assign resp_owner  = !fire ? CELL_EMPTY :
                        oob_q ? CELL_WALL : ram_rdata;
   assign crash_a     = crash_a_q;
   assign crash_b     = crash_b_q;

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      x_d        = x_q;
      y_d        = y_q;
      player_d   = player_q;
      oob_d      = oob_q;
      crash_a_d  = crash_a_q;
      crash_b_d  = crash_b_q;
      ram_we     = 1'b0;
      ram_addr   = clr_addr_q;
      ram_wdata  = CELL_EMPTY;
      unique case (state_q)
         ST_CLEAR: begin
            ram_we     = 1'b1;
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == LAST) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (req_valid) begin
               x_d      = req_x;
               y_d      = req_y;
               player_d = req_player;
               oob_d    = (int'(req_x) >= FIELD_W) ||
                          (int'(req_y) >= FIELD_H);
               state_d  = ST_READ;
            end
         end
         ST_READ: begin
            ram_addr = oob_q ? '0 : rd_addr;
            state_d  = ST_CHECK;
         end
         ST_CHECK: begin
            ram_addr = oob_q ? '0 : rd_addr;
            if (!hit) begin
               ram_we    = 1'b1;
               ram_wdata = cell_code(player_q);
            end else if (player_q == PLAYER_B) begin
               crash_b_d = 1'b1;
            end else begin
               crash_a_d = 1'b1;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_CLEAR;
      endcase
      if (clear) begin
         state_d    = ST_CLEAR;
         clr_addr_d = '0;
         crash_a_d  = 1'b0;
         crash_b_d  = 1'b0;
         ram_we     = 1'b0;
      end
      if (reset) begin
         ram_we = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_CLEAR;
         clr_addr_q <= '0;
         x_q        <= '0;
         y_q        <= '0;
         player_q   <= 1'b0;
         oob_q      <= 1'b0;
         crash_a_q  <= 1'b0;
         crash_b_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         x_q        <= x_d;
         y_q        <= y_d;
         player_q   <= player_d;
         oob_q      <= oob_d;
         crash_a_q  <= crash_a_d;
         crash_b_q  <= crash_b_d;
      end
   end

   occupancy_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (ram_we),
      .addr_i  (ram_addr),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );

endmodule

// File: tb/tb_trail_collision_checker.sv
// Directed bench for trail_collision_checker with a queue-based
// scoreboard checked by an independent response monitor.
module tb_trail_collision_checker;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       clear = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [7:0] req_x = '0;
   logic [6:0] req_y = '0;
   logic       req_player = 1'b0;
   logic       resp_valid;
   logic       resp_hit;
   logic       resp_player;
   logic [1:0] resp_owner;
   logic       crash_a;
   logic       crash_b;
   logic       busy_clear;

   typedef struct {
      logic       hit;
      logic       player;
      logic [1:0] owner;
      int         acc;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   trail_collision_checker dut (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_x       (req_x),
      .req_y       (req_y),
      .req_player  (req_player),
      .resp_valid  (resp_valid),
      .resp_hit    (resp_hit),
      .resp_player (resp_player),
      .resp_owner  (resp_owner),
      .crash_a     (crash_a),
      .crash_b     (crash_b),
      .busy_clear  (busy_clear)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (resp_valid) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got valid want none");
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("resp_hit", int'(resp_hit), int'(e.hit));
            chk("resp_player", int'(resp_player), int'(e.player));
            chk("resp_owner", int'(resp_owner), int'(e.owner));
            chk("latency", cyc - e.acc, 2);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int x, input int y, input logic p,
                       input logic eh, input logic [1:0] eo,
                       input bit push, input bit hold,
                       output int acc);
      int n;
      exp_t e;
      req_x      = 8'(x);
      req_y      = 7'(y);
      req_player = p;
      req_valid  = 1'b1;
      n = 0;
      while (!req_ready && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) begin
         chk("req_ready_timeout", 0, 1);
      end
      acc = cyc;
      if (push) begin
         e.hit = eh;
         e.player = p;
         e.owner = eo;
         e.acc = acc;
         q.push_back(e);
      end
      tick();
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      if (q.size() != 0) begin
         chk("resp_timeout", q.size(), 0);
         q.delete();
      end
      tick();
   endtask

   task automatic measure_wipe(input string name);
      int n;
      bit rdy_seen;
      n = 0;
      rdy_seen = 0;
      while (busy_clear && n < 30000) begin
         if (req_ready) rdy_seen = 1;
         tick();
         n++;
      end
      chk(name, n, 19200);
      chk("ready_during_wipe", int'(rdy_seen), 0);
      chk("ready_after_wipe", int'(req_ready), 1);
   endtask

   initial begin
      int a0, a1, a2, d;
      tick();
      tick();
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_resp_valid", int'(resp_valid), 0);
      chk("rst_busy_clear", int'(busy_clear), 1);
      chk("rst_crash_a", int'(crash_a), 0);
      chk("rst_crash_b", int'(crash_b), 0);
      reset = 1'b0;
      measure_wipe("wipe_len_reset");

      send(0, 0, 1'b0, 1'b0, 2'b00, 1, 0, d);
      send(159, 0, 1'b0, 1'b0, 2'b00, 1, 0, d);
      send(0, 119, 1'b1, 1'b0, 2'b00, 1, 0, d);
      send(159, 119, 1'b1, 1'b0, 2'b00, 1, 0, d);
      send(80, 60, 1'b0, 1'b0, 2'b00, 1, 0, d);
      drain();

      send(25, 25, 1'b0, 1'b0, 2'b00, 1, 0, d);
      send(25, 25, 1'b1, 1'b1, 2'b01, 1, 0, d);
      drain();
      chk("t2_crash_b", int'(crash_b), 1);
      chk("t2_crash_a", int'(crash_a), 0);

      send(255, 10, 1'b0, 1'b1, 2'b11, 1, 0, d);
      send(10, 120, 1'b1, 1'b1, 2'b11, 1, 0, d);
      drain();
      chk("t3_crash_a", int'(crash_a), 1);
      chk("t3_crash_b", int'(crash_b), 1);
      send(95, 11, 1'b1, 1'b0, 2'b00, 1, 0, d);
      drain();
      chk("t3_crash_b_hold", int'(crash_b), 1);

      send(25, 25, 1'b0, 1'b0, 2'b00, 0, 0, d);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("t4_crash_a", int'(crash_a), 0);
      chk("t4_crash_b", int'(crash_b), 0);
      measure_wipe("wipe_len_clear");
      send(25, 25, 1'b0, 1'b0, 2'b00, 1, 0, d);
      drain();

      send(100, 100, 1'b0, 1'b0, 2'b00, 1, 1, a0);
      send(101, 100, 1'b0, 1'b0, 2'b00, 1, 1, a1);
      send(100, 100, 1'b0, 1'b1, 2'b01, 1, 0, a2);
      drain();
      chk("t5_spacing_1", a1 - a0, 3);
      chk("t5_spacing_2", a2 - a1, 3);
      chk("t5_crash_a", int'(crash_a), 1);

      send(70, 80, 1'b1, 1'b0, 2'b00, 0, 0, d);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      measure_wipe("wipe_len_reset2");
      send(70, 80, 1'b1, 1'b0, 2'b00, 1, 0, d);
      drain();
      chk("t6_crash_b", int'(crash_b), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
